// File: rtl/serial_feeder_pkg.sv
// rtl/serial_feeder_pkg.sv - shared constants and FSM state type for the serial bit feeder
//
// Purpose: default word width and the feeder state enumeration, imported by
//          bit_counter and serial_bit_feeder.
// Ports:   none (package).
package serial_feeder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - remaining-bit counter for the serial bit feeder
//
// Purpose: counts the data bits still to follow the one currently on x.
//          Loads WIDTH-1 on accept, decrements once per shifted bit and
//          saturates at zero, so it never wraps.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-high reset (clears the count)
//   load_i  - reload with WIDTH-1 (a new word was accepted)
//   dec_i   - one data bit was consumed
//   last_o  - the bit on x is the final data bit of the word
module bit_counter
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic last_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(WIDTH - 1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/serial_bit_feeder.sv
// rtl/serial_bit_feeder.sv - parallel word to MSB-first serial bit stream
//
// Purpose: accepts a WIDTH-bit word with a valid/ready handshake and emits it
//          MSB first on x, one bit per cycle, with an optional trailing
//          even-parity bit. Back-to-back words stream without gaps.
// Configuration: define SERIAL_BIT_FEEDER_PARITY_EN to append the parity bit
//          (frame becomes WIDTH+1 cycles); undefined, the PARITY state is
//          never entered and no parity logic is built.
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-high reset
//   din       - parallel word on offer
//   din_valid - din holds a word
//   din_ready - a word can be accepted this cycle
//   x         - serial bit stream
//   x_valid   - x carries a meaningful bit
//   busy      - a frame is being shifted out
module serial_bit_feeder
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy
);

  feeder_state_e    state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             cnt_load, cnt_dec, cnt_last;
  logic             ready_int;
  logic             accept;

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .last_o (cnt_last)
  );

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  logic par_q, par_d;

  // With parity the final frame bit is the parity bit, not the last data bit.
  assign ready_int = (state_q == IDLE) || (state_q == PARITY);
`else
  assign ready_int = (state_q == IDLE) || ((state_q == SHIFT) && cnt_last);
`endif

  // Gated with reset so nothing is offered or accepted while reset is held.
  assign din_ready = ready_int && !reset;
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SHIFT;
          sh_d     = din;
          cnt_load = 1'b1;
        end
      end
      SHIFT: begin
        if (!cnt_last) begin
          sh_d    = {sh_q[WIDTH-2:0], 1'b0};
          cnt_dec = 1'b1;
        end else begin
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
          state_d = PARITY;
`else
          if (accept) begin
            sh_d     = din;
            cnt_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
      PARITY: begin
        if (accept) begin
          state_d  = SHIFT;
          sh_d     = din;
          cnt_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
    end
  end

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  // Parity is computed from din at accept time so it is ready when the
  // shift register has been emptied.
  assign par_d = accept ? ^din : par_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  always_comb begin
    x = 1'b0;
    case (state_q)
      SHIFT:   x = sh_q[WIDTH-1];
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
      PARITY:  x = par_q;
`endif
      default: x = 1'b0;
    endcase
  end

  assign x_valid = (state_q != IDLE);
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb/tb_serial_bit_feeder.sv - self-checking bench for serial_bit_feeder
module tb_serial_bit_feeder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, x, x_valid, busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference: queue of frame bits still to appear on x; head is on x now.
  bit       model_q[$];
  logic [4:0] hist = '0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .x         (x),
    .x_valid   (x_valid),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".din_ready"}, din_ready, 1'b0);
    check({tag, ".x"},         x,         1'b0);
    check({tag, ".x_valid"},   x_valid,   1'b0);
    check({tag, ".busy"},      busy,      1'b0);
  endtask

  task automatic check_model(input string tag);
    logic exp_x;
    exp_x = (model_q.size() > 0) ? logic'(model_q[0]) : 1'b0;
    check({tag, ".x"},         x,         exp_x);
    check({tag, ".x_valid"},   x_valid,   logic'(model_q.size() > 0));
    check({tag, ".busy"},      busy,      logic'(model_q.size() > 0));
    check({tag, ".din_ready"}, din_ready, logic'(model_q.size() <= 1));
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) model_q.push_back(d[i]);
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    model_q.push_back(^d);
`endif
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic step(input string tag, input logic v, input logic [W-1:0] d);
    bit rdy;
    din_valid = v;
    din = d;
    #1;
    check_model(tag);
    if (x_valid) hist = {hist[3:0], x};
    rdy = (model_q.size() <= 1);
    @(posedge clk);
    if (model_q.size() > 0) void'(model_q.pop_front());
    if (v && rdy) push_frame(d);
    @(negedge clk);
  endtask

  initial begin
    bit acc;

    // Reset held with a word on offer: nothing may be accepted or emitted.
    din_valid = 1'b1;
    din = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      check_idle_zero("rst_hold");
    end
    reset = 1'b0;
    din_valid = 1'b0;

    // Single word 0x13; first accept on the first edge after reset release.
    step("acc13", 1'b1, 8'h13);
    hist = '0;
    repeat (W) step("f13", 1'b0, W'($urandom));
    check("det10011", logic'(hist == 5'b10011), 1'b1);
    repeat (3) step("idle1", 1'b0, W'($urandom));

    // 0x13 followed by 0xA5 offered continuously: gapless hand-over.
    step("b2b_acc", 1'b1, 8'h13);
    acc = 1'b0;
    for (int i = 0; i < W + 2 && !acc; i++) begin
      acc = (model_q.size() <= 1);
      step("b2b", 1'b1, 8'hA5);
    end
    check("b2b_taken", logic'(acc), 1'b1);
    repeat (W + 2) step("b2b_drain", 1'b0, W'($urandom));

    // din changes and din_valid toggles while the word is in flight.
    step("hold_acc", 1'b1, 8'hC3);
    for (int i = 0; i < W - 1; i++) step("hold", logic'(i % 2), 8'h3C);
    repeat (W + 2) step("hold_drain", 1'b0, W'($urandom));

    // Asynchronous reset in the middle of 0xFF.
    step("ff_acc", 1'b1, 8'hFF);
    repeat (2) step("ff", 1'b0, W'($urandom));
    #2 reset = 1'b1;
    #1 check_idle_zero("async_rst");
    model_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_idle_zero("rst_held");
    reset = 1'b0;
    repeat (W + 2) step("post_rst", 1'b0, W'($urandom));

    // Random offers and words.
    repeat (300) step("rand", logic'($urandom_range(0, 9) < 7), W'($urandom));
    repeat (W + 2) step("rand_drain", 1'b0, W'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_bit_feeder.md
SERIAL_BIT_FEEDER -- requirements
Module: serial_bit_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the number of data bits per word.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port din, input, WIDTH bits: the parallel word to serialize.
REQ-005 SHALL have port din_valid, input, 1 bit: din holds a word on offer.
REQ-006 SHALL have port din_ready, output, 1 bit: the block can accept a word this cycle.
REQ-007 SHALL have port x, output, 1 bit: the serial bit stream for the downstream sequence detector.
REQ-008 SHALL have port x_valid, output, 1 bit: x carries a meaningful bit this cycle.
REQ-009 SHALL have port busy, output, 1 bit: a word or parity bit is being shifted out.

Function
REQ-010 SHALL accept a word on a rising edge where din_valid=1 and din_ready=1, capturing din into an internal shift register.
REQ-011 SHALL drive din_ready=1 in IDLE, or on the cycle the final serial bit of the current frame is on x; otherwise din_ready=0.
REQ-012 SHALL drive x from registered state only, so x and x_valid do not depend combinationally on din or din_valid.
REQ-013 SHALL drive the first bit, din[WIDTH-1] (MSB first), on x with x_valid=1 in the cycle after acceptance; latency is 1 cycle.
REQ-014 SHALL output one bit per cycle on x: din[WIDTH-1] down to din[0], over WIDTH consecutive cycles, with no gaps.
REQ-015 SHALL implement FSM states IDLE, SHIFT and PARITY.
REQ-016 SHALL take these transitions: IDLE to SHIFT on accept; SHIFT to SHIFT while bits remain.
REQ-017 SHALL take these transitions at the end of the last data bit: to PARITY when parity is compiled in; else to SHIFT if a new word is accepted; else to IDLE.
REQ-018 SHALL leave PARITY after one cycle: to SHIFT if a new word is accepted that cycle, else to IDLE.
REQ-019 SHALL, on back-to-back accept during the final bit, present the new word's MSB in the very next cycle with x_valid held at 1.
REQ-020 SHALL count bits with a ceil(log2(WIDTH+1))-bit counter that reloads on accept and never wraps past WIDTH-1.
REQ-021 SHALL drive x=0 and x_valid=0 in IDLE.
REQ-022 SHALL drive busy=1 exactly when the state is not IDLE.
REQ-023 SHALL ignore din_valid while din_ready=0, leaving the word in flight unaltered.

Reset
REQ-024 SHALL, while reset=1 and independent of clk, force state to IDLE, clear the shift register and counter, and drive x=0, x_valid=0, busy=0, din_ready=0.
REQ-025 SHALL abandon a frame in flight when reset asserts mid-frame, emitting no further bits of it.
REQ-026 SHALL permit the first accept on the first rising edge after reset deasserts.

Configuration
REQ-027 SHALL compile in the parity feature under macro SERIAL_BIT_FEEDER_PARITY_EN.
REQ-028 SHALL, with the macro defined, append one even-parity bit (XOR of all WIDTH data bits) after din[0], with x_valid=1; the frame is WIDTH+1 cycles.
REQ-029 SHALL, without the macro, omit the PARITY state and its logic entirely; the frame is WIDTH cycles.

Structure
REQ-030 SHALL take the state enumeration (IDLE, SHIFT, PARITY) and the default WIDTH constant from shared package serial_feeder_pkg.
REQ-031 SHALL implement the bit counter (load, decrement, last flag) as one sub-module named bit_counter; all other logic stays in the top module.

Verification
REQ-032 SHALL cover: reset held 3 cycles with din_valid=1 -> din_ready=0, x=0, x_valid=0, busy=0 throughout.
REQ-033 SHALL cover: accept din=8'h13, macro off -> x = 0,0,0,1,0,0,1,1 on cycles 1-8, x_valid=1; a chained Mealy 10011 detector asserts z on the eighth bit.
REQ-034 SHALL cover: din=8'h13 then 8'hA5 offered continuously -> 16 contiguous x_valid cycles, 8'hA5 MSB (1) immediately after the final 1 of 8'h13.
REQ-035 SHALL cover: macro on, din=8'h13 -> 8 data bits followed by parity bit 1 (three ones); din_ready=1 only on the parity cycle.
REQ-036 SHALL cover: reset asserted after bit 3 of 8'hFF -> x=0 and x_valid=0 immediately (asynchronous), no further bits, IDLE after release.
REQ-037 SHALL cover: din_valid toggled during SHIFT with a differing din -> output stream matches the originally accepted word exactly.
